// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing sequencers: condition codes, ALU opcodes,
// FSM state encoding and opcode classification helpers.
package dp_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COND  = 3'd1,
    ST_READ  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // TST/TEQ/CMP/CMN: always set flags, never write a register
  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  // Logical ops take C from the shifter and leave V alone
  function automatic logic is_logical_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluator against NZVC flags; purely combinational so it can be
// shared by any sequencer that needs conditional execution.
module cond_check
  import dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, v, c;

  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    v    = flags[FLAG_V];
    c    = flags[FLAG_C];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_exec_seq.sv
// Multi-cycle sequencer for one ARM data-processing instruction: condition check,
// Rn read, ALU execute and register/flag write-back, with the CPSR NZVC held locally.
module dp_exec_seq
  import dp_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        cond,
  input  logic [3:0]        opcode,
  input  logic              s_bit,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   op2,
  input  logic              shift_carry,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [3:0]        alu_opcode,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic              alu_carry_in,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [3:0]        alu_nzvc,
  output logic [3:0]        flags,
  output logic              done,
  output logic              skipped
);

  state_t            state_reg;
  logic [3:0]        cond_reg;
  logic [3:0]        opcode_reg;
  logic              s_reg;
  logic              sc_reg;
  logic [REG_AW-1:0] rn_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [XLEN-1:0]   op2_reg;
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   res_reg;
  logic [3:0]        nzvc_reg;
  logic [3:0]        flags_reg;
  logic [3:0]        flags_next;

  logic              ready_reg;
  logic              we_reg;
  logic              done_reg;
  logic [REG_AW-1:0] raddr_reg;
  logic [REG_AW-1:0] waddr_reg;
  logic [3:0]        alu_op_reg;
  logic [XLEN-1:0]   alu_b_reg;
  logic              alu_cin_reg;

  logic cond_pass;
  logic skip_now;

  cond_check u_cond_check (
    .cond  (cond_reg),
    .flags (flags_reg),
    .pass  (cond_pass)
  );

  assign skip_now = (state_reg == ST_COND) && !cond_pass;

  // Logical ops keep V and take C from the shifter; arithmetic ops take all four
  always_comb begin
    flags_next = nzvc_reg;
    if (is_logical_op(opcode_reg)) begin
      flags_next[FLAG_N] = nzvc_reg[FLAG_N];
      flags_next[FLAG_Z] = nzvc_reg[FLAG_Z];
      flags_next[FLAG_V] = flags_reg[FLAG_V];
      flags_next[FLAG_C] = sc_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cond_reg    <= '0;
      opcode_reg  <= '0;
      s_reg       <= 1'b0;
      sc_reg      <= 1'b0;
      rn_reg      <= '0;
      rd_reg      <= '0;
      op2_reg     <= '0;
      a_reg       <= '0;
      res_reg     <= '0;
      nzvc_reg    <= '0;
      flags_reg   <= '0;
      ready_reg   <= 1'b1;
      we_reg      <= 1'b0;
      done_reg    <= 1'b0;
      raddr_reg   <= '0;
      waddr_reg   <= '0;
      alu_op_reg  <= '0;
      alu_b_reg   <= '0;
      alu_cin_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid && ready_reg) begin
            cond_reg   <= cond;
            opcode_reg <= opcode;
            s_reg      <= s_bit;
            sc_reg     <= shift_carry;
            rn_reg     <= rn;
            rd_reg     <= rd;
            op2_reg    <= op2;
            // Address goes out during COND so the synchronous read lands in READ
            raddr_reg  <= rn;
            ready_reg  <= 1'b0;
            state_reg  <= ST_COND;
          end
        end
        ST_COND: begin
          if (cond_pass) begin
            raddr_reg <= rn_reg;
            state_reg <= ST_READ;
          end else begin
            raddr_reg <= '0;
            ready_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        ST_READ: begin
          a_reg       <= rf_rdata;
          alu_op_reg  <= opcode_reg;
          alu_b_reg   <= op2_reg;
          alu_cin_reg <= flags_reg[FLAG_C];
          raddr_reg   <= '0;
          state_reg   <= ST_EXEC;
        end
        ST_EXEC: begin
          res_reg     <= alu_res;
          nzvc_reg    <= alu_nzvc;
          we_reg      <= !is_test_op(opcode_reg);
          waddr_reg   <= rd_reg;
          done_reg    <= 1'b1;
          a_reg       <= '0;
          alu_op_reg  <= '0;
          alu_b_reg   <= '0;
          alu_cin_reg <= 1'b0;
          state_reg   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (s_reg || is_test_op(opcode_reg)) begin
            flags_reg <= flags_next;
          end
          we_reg    <= 1'b0;
          done_reg  <= 1'b0;
          waddr_reg <= '0;
          res_reg   <= '0;
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready  = ready_reg;
  assign rf_raddr     = raddr_reg;
  assign rf_we        = we_reg;
  assign rf_waddr     = waddr_reg;
  assign rf_wdata     = res_reg;
  assign alu_opcode   = alu_op_reg;
  assign alu_a        = a_reg;
  assign alu_b        = alu_b_reg;
  assign alu_carry_in = alu_cin_reg;
  assign flags        = flags_reg;
  // A failed condition retires straight out of COND
  assign done         = done_reg || skip_now;
  assign skipped      = skip_now;

endmodule

// File: tb/tb_dp_exec_seq.sv
// Bench for dp_exec_seq: register-file and ALU models around the DUT, an instruction-level
// reference model that predicts per-cycle outputs, and directed instruction vectors.
module tb_dp_exec_seq;
  import dp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  cond = '0;
  logic [3:0]  opcode = '0;
  logic        s_bit = 1'b0;
  logic [3:0]  rn = '0;
  logic [3:0]  rd = '0;
  logic [31:0] op2 = '0;
  logic        shift_carry = 1'b0;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_carry_in;
  logic [31:0] alu_res;
  logic [3:0]  alu_nzvc;
  logic [3:0]  flags;
  logic        done;
  logic        skipped;

  dp_exec_seq #(.REG_AW(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .cond(cond), .opcode(opcode), .s_bit(s_bit), .rn(rn), .rd(rd),
    .op2(op2), .shift_carry(shift_carry),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_res(alu_res), .alu_nzvc(alu_nzvc),
    .flags(flags), .done(done), .skipped(skipped)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int txn    = 0;

  // ARM ALU behaviour: returns {N,Z,V,C,result}
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    logic [31:0] r, x, y;
    logic [32:0] t;
    logic        c, v, ci, arith;
    arith = 1'b1; c = cin; v = 1'b0; x = a; y = b; ci = 1'b0; r = '0;
    case (op)
      4'h0, 4'h8: begin arith = 1'b0; r = a & b; end
      4'h1, 4'h9: begin arith = 1'b0; r = a ^ b; end
      4'h2, 4'hA: begin y = ~b; ci = 1'b1; end
      4'h3:       begin x = b; y = ~a; ci = 1'b1; end
      4'h4, 4'hB: begin ci = 1'b0; end
      4'h5:       begin ci = cin; end
      4'h6:       begin y = ~b; ci = cin; end
      4'h7:       begin x = b; y = ~a; ci = cin; end
      4'hC:       begin arith = 1'b0; r = a | b; end
      4'hD:       begin arith = 1'b0; r = b; end
      4'hE:       begin arith = 1'b0; r = a & ~b; end
      default:    begin arith = 1'b0; r = ~b; end
    endcase
    if (arith) begin
      t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      r = t[31:0];
      c = t[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end
    return {r[31], (r == 32'd0), v, c, r};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Bench-side ALU and synchronous-read register file
  always_comb {alu_nzvc, alu_res} = alu_fn(alu_opcode, alu_a, alu_b, alu_carry_in);

  logic [31:0] rf_mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) rf_mem[pre_addr] <= pre_data;
    if (rf_we)  rf_mem[rf_waddr] <= rf_wdata;
    rf_rdata <= rf_mem[rf_raddr];
  end

  // Reference model state
  logic [31:0] m_regs [16];
  logic [3:0]  m_flags = 4'b0000;

  typedef struct {
    int          id;
    logic        ready, done, skipped, we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  flags;
    logic        chk_raddr;
    logic [3:0]  raddr;
    logic        chk_alu;
    logic [3:0]  aop;
    logic [31:0] aa, ab;
    logic        acin;
  } exp_t;

  exp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t base(input int id, input logic [3:0] f);
    exp_t e;
    e.id = id; e.ready = 1'b0; e.done = 1'b0; e.skipped = 1'b0; e.we = 1'b0;
    e.waddr = '0; e.wdata = '0; e.flags = f; e.chk_raddr = 1'b0; e.raddr = '0;
    e.chk_alu = 1'b0; e.aop = '0; e.aa = '0; e.ab = '0; e.acin = 1'b0;
    return e;
  endfunction

  // Single compare process: one expected entry per cycle while an instruction is in flight
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("i%0d ready", e.id), 32'(instr_ready), 32'(e.ready));
      check($sformatf("i%0d done", e.id), 32'(done), 32'(e.done));
      check($sformatf("i%0d skipped", e.id), 32'(skipped), 32'(e.skipped));
      check($sformatf("i%0d rf_we", e.id), 32'(rf_we), 32'(e.we));
      check($sformatf("i%0d flags", e.id), 32'(flags), 32'(e.flags));
      if (e.we) begin
        check($sformatf("i%0d rf_waddr", e.id), 32'(rf_waddr), 32'(e.waddr));
        check($sformatf("i%0d rf_wdata", e.id), rf_wdata, e.wdata);
      end
      if (e.chk_raddr) check($sformatf("i%0d rf_raddr", e.id), 32'(rf_raddr), 32'(e.raddr));
      if (e.chk_alu) begin
        check($sformatf("i%0d alu_opcode", e.id), 32'(alu_opcode), 32'(e.aop));
        check($sformatf("i%0d alu_a", e.id), alu_a, e.aa);
        check($sformatf("i%0d alu_b", e.id), alu_b, e.ab);
        check($sformatf("i%0d alu_carry_in", e.id), 32'(alu_carry_in), 32'(e.acin));
      end
    end
  end

  task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    m_regs[a] = d;
  endtask

  // Issue one instruction, predict its per-cycle outputs, return one cycle before it is ready again
  task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic s,
                       input logic [3:0] n, input logic [3:0] d, input logic [31:0] b,
                       input logic sc);
    logic [35:0] r;
    logic [3:0]  nf;
    logic        pass;
    exp_t        e;
    int          len;
    @(negedge clk);
    instr_valid = 1'b1; cond = c; opcode = op; s_bit = s;
    rn = n; rd = d; op2 = b; shift_carry = sc;
    @(posedge clk); #1;
    // Scramble the fields: the sequencer must only use what it latched
    instr_valid = 1'b0; cond = ~c; opcode = ~op; s_bit = ~s;
    rn = ~n; rd = ~d; op2 = ~b; shift_carry = ~sc;
    txn++;
    pass = cond_ok(c, m_flags);
    if (!pass) begin
      e = base(txn, m_flags); e.done = 1'b1; e.skipped = 1'b1; exp_q.push_back(e);
      e = base(txn, m_flags); e.ready = 1'b1; exp_q.push_back(e);
      len = 2;
      $display("txn %0d: cond=%h op=%h rd=%0d skipped", txn, c, op, d);
    end else begin
      r  = alu_fn(op, m_regs[n], b, m_flags[0]);
      nf = m_flags;
      if (s || op[3:2] == 2'b10) begin
        if (op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF})
          nf = {r[35], r[34], m_flags[1], sc};
        else
          nf = r[35:32];
      end
      e = base(txn, m_flags); exp_q.push_back(e);
      e = base(txn, m_flags); e.chk_raddr = 1'b1; e.raddr = n; exp_q.push_back(e);
      e = base(txn, m_flags); e.chk_alu = 1'b1; e.aop = op; e.aa = m_regs[n];
      e.ab = b; e.acin = m_flags[0]; exp_q.push_back(e);
      e = base(txn, m_flags); e.done = 1'b1; e.we = (op[3:2] != 2'b10);
      e.waddr = d; e.wdata = r[31:0]; exp_q.push_back(e);
      e = base(txn, nf); e.ready = 1'b1; exp_q.push_back(e);
      if (op[3:2] != 2'b10) m_regs[d] = r[31:0];
      m_flags = nf;
      len = 5;
      $display("txn %0d: cond=%h op=%h rd=%0d result=%h flags=%b", txn, c, op, d, r[31:0], nf);
    end
    repeat (len - 1) @(negedge clk);
  endtask

  // Look at the DUT just after the retiring edge
  task automatic pin(input string name, input logic [31:0] act_now_unused, input logic [31:0] req);
    check(name, act_now_unused, req);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, sampled while reset is still asserted
    repeat (2) @(posedge clk);
    #1;
    check("reset instr_ready", 32'(instr_ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset skipped", 32'(skipped), 32'd0);
    check("reset rf_we", 32'(rf_we), 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    check("reset alu_a", alu_a, 32'd0);
    check("reset rf_raddr", 32'(rf_raddr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) set_reg(4'(i), 32'h1111_1111 * i);

    // ADDS r2 = 0x7FFFFFFF + 1
    set_reg(4'd1, 32'h7FFF_FFFF);
    issue(COND_AL, OP_ADD, 1'b1, 4'd1, 4'd2, 32'd1, 1'b0);
    @(posedge clk); #1;
    pin("adds flags", 32'(flags), 32'(4'b1010));
    pin("adds r2", rf_mem[2], 32'h8000_0000);
    pin("model adds flags", 32'(m_flags), 32'(4'b1010));

    // CMP without S still sets flags, no write
    set_reg(4'd1, 32'd5);
    issue(COND_AL, OP_CMP, 1'b0, 4'd1, 4'd0, 32'd5, 1'b0);
    @(posedge clk); #1;
    pin("cmp flags", 32'(flags), 32'(4'b0101));

    // NE with Z=1 is skipped
    issue(COND_NE, OP_ADD, 1'b0, 4'd1, 4'd6, 32'd1, 1'b0);
    @(posedge clk); #1;
    pin("skip flags", 32'(flags), 32'(4'b0101));

    // Set V, then ANDS keeps V and takes C from the shifter
    set_reg(4'd1, 32'h7FFF_FFFF);
    issue(COND_AL, OP_ADD, 1'b1, 4'd1, 4'd2, 32'd1, 1'b0);
    set_reg(4'd1, 32'h0000_00F0);
    issue(COND_AL, OP_AND, 1'b1, 4'd1, 4'd7, 32'h0000_000F, 1'b1);
    @(posedge clk); #1;
    pin("ands flags", 32'(flags), 32'(4'b0111));
    pin("ands r7", rf_mem[7], 32'd0);

    // ADCS with carry in, then back-to-back ADD CS
    set_reg(4'd1, 32'hFFFF_FFFF);
    issue(COND_AL, OP_ADC, 1'b1, 4'd1, 4'd8, 32'd0, 1'b0);
    @(posedge clk); #1;
    pin("adcs flags", 32'(flags), 32'(4'b0101));
    issue(COND_CS, OP_ADD, 1'b0, 4'd1, 4'd3, 32'd2, 1'b0);
    @(posedge clk); #1;
    pin("add cs r3", rf_mem[3], 32'd1);
    pin("adcs r8", rf_mem[8], 32'd0);

    // Mixed opcodes and condition codes, mostly back-to-back
    set_reg(4'd9, 32'h8000_0000);
    set_reg(4'd10, 32'd3);
    issue(COND_AL, OP_SUB, 1'b1, 4'd10, 4'd11, 32'd5, 1'b0);
    issue(COND_GE, OP_ADD, 1'b1, 4'd10, 4'd11, 32'd5, 1'b0);
    issue(COND_LT, OP_RSB, 1'b1, 4'd10, 4'd12, 32'd5, 1'b0);
    issue(COND_HI, OP_EOR, 1'b1, 4'd9, 4'd13, 32'h8000_0000, 1'b0);
    issue(COND_LE, OP_MVN, 1'b1, 4'd10, 4'd14, 32'd0, 1'b1);
    issue(COND_NV, OP_MOV, 1'b1, 4'd10, 4'd14, 32'd7, 1'b0);
    issue(COND_AL, OP_CMN, 1'b0, 4'd9, 4'd0, 32'h8000_0000, 1'b0);
    issue(COND_VS, OP_SBC, 1'b1, 4'd10, 4'd4, 32'd1, 1'b0);
    issue(COND_AL, OP_TEQ, 1'b0, 4'd10, 4'd5, 32'd3, 1'b1);
    issue(COND_EQ, OP_MOV, 1'b0, 4'd10, 4'd15, 32'h0000_1234, 1'b0);
    issue(COND_AL, OP_BIC, 1'b1, 4'd9, 4'd0, 32'h8000_0000, 1'b0);
    issue(COND_MI, OP_RSC, 1'b1, 4'd10, 4'd1, 32'd9, 1'b0);
    issue(COND_GT, OP_ORR, 1'b0, 4'd10, 4'd6, 32'h0000_0F00, 1'b0);
    @(posedge clk); #1;
    pin("mov r15", rf_mem[15], 32'h0000_1234);

    // Reset during EXEC of a SUBS aborts it
    set_reg(4'd4, 32'h0000_0010);
    set_reg(4'd5, 32'h0000_DEAD);
    @(negedge clk);
    instr_valid = 1'b1; cond = COND_AL; opcode = OP_SUB; s_bit = 1'b1;
    rn = 4'd4; rd = 4'd5; op2 = 32'd3; shift_carry = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    txn++;
    $display("txn %0d: cond=%h op=%h rd=%0d aborted by reset in EXEC", txn, COND_AL, OP_SUB, 4'd5);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort instr_ready", 32'(instr_ready), 32'd1);
    check("abort rf_we", 32'(rf_we), 32'd0);
    check("abort flags", 32'(flags), 32'd0);
    check("abort done", 32'(done), 32'd0);
    m_flags = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort r5 untouched", rf_mem[5], 32'h0000_DEAD);

    // A fresh instruction after the abort
    issue(COND_AL, OP_ORR, 1'b1, 4'd4, 4'd5, 32'h0F00_0000, 1'b0);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 16; i++)
      check($sformatf("final r%0d", i), rf_mem[i], m_regs[i]);
    check("final flags", 32'(flags), 32'(m_flags));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_exec_seq.md
Name: dp_exec_seq

Overview:
- Multi-cycle sequencer for one ARM data-processing instruction at a time.
- Accepts a decoded instruction from decode over a valid/ready handshake and evaluates its condition field against the CPSR flags it owns.
- Reads operand Rn from the register file, drives the shared ALU, and writes the result back.
- Updates NZCV when S is set, or always for test/compare opcodes. It sits between decode/barrel shifter and the ALU/register file.

Parameters:
- REG_AW, 4, register file address width.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active high.
- instr_valid  in  1  decode presents an instruction.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- cond  in  4  ARM condition field.
- opcode  in  4  ALU opcode; same encoding the ALU uses (0000 AND … 1111 MVN).
- s_bit  in  1  set-flags bit.
- rn  in  REG_AW  first operand register.
- rd  in  REG_AW  destination register.
- op2  in  XLEN  shifted operand from the barrel shifter.
- shift_carry  in  1  shifter carry-out.
- rf_raddr  out  REG_AW  register file read address.
- rf_rdata  in  XLEN  read data, valid one cycle after the address (synchronous read).
- rf_we  out  1  write enable, one-cycle pulse.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  XLEN  write data.
- alu_opcode  out  4  to ALU.
- alu_a  out  XLEN  to ALU.
- alu_b  out  XLEN  to ALU.
- alu_carry_in  out  1  to ALU.
- alu_res  in  XLEN  ALU result (combinational).
- alu_nzvc  in  4  ALU flags; [3]=N [2]=Z [1]=V [0]=C.
- flags  out  4  CPSR NZVC, same bit order as alu_nzvc.
- done  out  1  one-cycle pulse when the instruction retires.
- skipped  out  1  qualifies done; condition failed.

Behaviour:
- Reset (async, rst=1): state=IDLE, flags=0000, all latched fields 0. Outputs rf_we=0, done=0, skipped=0, instr_ready=1, alu_* and rf_* = 0.
- Reset mid-instruction aborts it. No write or flag update occurs.
- States: IDLE → COND → READ → EXEC → WRITE → IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch cond/opcode/s_bit/rn/rd/op2/shift_carry and go to COND.
  - Inputs are ignored outside this acceptance cycle.
- COND: evaluate the latched cond against flags.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 (NV) 0.
  - Fail → IDLE, pulsing done=1 and skipped=1 in the transition cycle; no write, flags unchanged.
  - Pass → READ.
- READ: rf_raddr=rn. Next edge captures rf_rdata into a_reg. Rn is read even for MOV/MVN, so latency is fixed.
- EXEC:
  - Drive alu_opcode=opcode, alu_a=a_reg, alu_b=op2, alu_carry_in=flags[0].
  - Capture alu_res and alu_nzvc into registers at the edge.
- WRITE:
  - rf_we=1 unless opcode is 10xx (TST/TEQ/CMP/CMN).
  - rf_waddr=rd, rf_wdata=captured result. done=1, skipped=0.
  - Flag update at the edge occurs if s_bit=1 or opcode is 10xx.
  - Arithmetic ops (0010-0111, 1010, 1011): flags ← captured nzvc.
  - Logical ops (0000, 0001, 1000, 1001, 1100-1111): N,Z ← captured; C ← latched shift_carry; V unchanged.
  - Next state IDLE.
- Latency: accept at edge 0, then COND, READ, EXEC, WRITE. done asserts in cycle 4, and instr_ready returns in cycle 5. A skipped instruction retires in cycle 1.
- Back-to-back: flags written in WRITE are visible to the next instruction's COND evaluation (no bypass needed, since COND is ≥2 cycles later).
- rd=15 is written like any register; PC side effects are out of scope.
- All ALU arithmetic is modulo 2^XLEN; the sequencer adds no width extension.

Decomposition:
- Shared package dp_pkg:
  - cond code constants (COND_EQ … COND_NV), opcode constants (OP_AND … OP_MVN);
  - state enum;
  - functions is_test_op(opcode) and is_logical_op(opcode);
  - flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0).
- One sub-module: cond_check (combinational; inputs cond and flags, output pass), reused later by branch/load-store sequencers.

Test Plan:
- Reset then ADDS r2=r1+op2 with r1=0x7FFFFFFF, op2=1, cond=AL → rf_we in cycle 4, waddr=2, wdata=0x80000000, flags NZVC=1010.
- With flags Z=1, issue ADD cond=NE → done=1, skipped=1 in cycle 1; rf_we never asserts; flags unchanged; instr_ready high next cycle.
- CMP (s_bit=0) r1=5, op2=5 → rf_we stays 0; flags become 0101 (Z=1, C=1).
- ANDS r1=0xF0, op2=0x0F, shift_carry=1, prior V=1 → wdata=0, flags N=0 Z=1 V=1 C=1.
- ADCS with C=1, r1=0xFFFFFFFF, op2=0 → wdata=0, flags 0101. Follow back-to-back with ADD cond=CS → executes.
- Assert rst during EXEC of a SUBS → no rf_we, flags=0000, instr_ready=1 immediately. A fresh instruction then completes normally.
